ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Sequences every SPARC RAM access (mov/r_w/type strobe, wait for MOC) and shares the RAM
//  between two requesters: the control unit (cpu) and the external load/dump port (ext,
//  preload and memory dump). Requests are arbitrated and latched, the RAM bus is driven, and a
//  one-cycle done pulse with read data or error is returned. Sits between CU/loader and SPARC_RAM.
// PARAMETERS
//  ADDR_W      9   RAM byte-address width
//  DATA_W      32  data width
//  TIMEOUT     15  max WAIT cycles for MOC before abort (>=1)
//  FIXED_PRIO  0   0 = round-robin on tie; 1 = cpu always wins tie
// PORTS
//  Clk        in   1       clock; all state changes on rising edge
//  Clr        in   1       reset, asynchronous, active-low
//  cpu_req    in   1       cpu request; hold req and fields stable until cpu_done
//  cpu_rw     in   1       1 = read, 0 = write
//  cpu_type   in   2       0 byte, 1 halfword, 2 word, 3 reserved (error)
//  cpu_addr   in   ADDR_W  byte address
//  cpu_wdata  in   DATA_W  write data (right-justified)
//  cpu_done   out  1       one-cycle completion pulse for cpu
//  ext_req/ext_rw/ext_type/ext_addr/ext_wdata  in   same as cpu_*
//  ext_done   out  1       one-cycle completion pulse for ext
//  rd_data    out  DATA_W  read data; valid with done, held until next read completes
//  err        out  1       valid with done: 1 = misaligned, reserved type, or MOC timeout
//  owner      out  1       0 = cpu, 1 = ext; current/last granted requester
//  busy       out  1       high in every state except IDLE
//  ram_mov    out  1       RAM strobe
//  ram_rw     out  1       RAM read/write (1 = read)
//  ram_type   out  2       RAM access size
//  ram_addr   out  ADDR_W  RAM address
//  ram_din    out  DATA_W  RAM write data
//  ram_dout   in   DATA_W  RAM read data
//  ram_moc    in   1       memory operation complete
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (rd_data = 0, owner = 0). Async: ram_mov drops at once,
//   any transaction in flight is discarded with no done.
//  FSM: IDLE -> SETUP -> STROBE -> WAIT -> RELEASE -> IDLE.
//  - IDLE: on any req pick a winner. Single req wins. On tie: FIXED_PRIO=1 gives cpu;
//    otherwise the requester not served last wins (after reset, cpu).
//    Latch rw/type/addr/wdata and owner.
//    Invalid access goes straight to RELEASE with err=1 and no RAM strobe:
//    type==3, halfword with addr[0]=1, or word with addr[1:0]!=0.
//    Valid access -> SETUP.
//  - SETUP: ram_rw/type/addr/din driven from latches, ram_mov=0 (one-cycle setup) -> STROBE.
//  - STROBE: ram_mov=1, timeout counter cleared -> WAIT.
//  - WAIT: ram_mov=1; ram_moc sampled only here.
//    moc=1: read latches ram_dout into rd_data -> RELEASE, err=0.
//    moc=0: counter++. Counter==TIMEOUT -> RELEASE with err=1 (rd_data unchanged).
//  - RELEASE: ram_mov=0; owner's done=1 for exactly this cycle, err valid -> IDLE.
//    ram_* address/data lines hold last values outside SETUP..WAIT.
//  - Latency: req sampled at edge k, MOC in first WAIT cycle -> done high in cycle after edge k+3.
//    Back-to-back from same requester: one full cycle of IDLE between done and next SETUP.
//  - Req deassert mid-transaction: ignored; transaction completes, done still pulses.
//  - moc high during SETUP/STROBE: ignored. Loser's req stays pending, served next IDLE.
//  - Counter width $clog2(TIMEOUT+1); it never wraps.
//  - Byte/halfword reads: rd_data = ram_dout zero-extended per type (low bits kept).
// TESTING
//  1 Reset mid-WAIT: Clr=0 -> ram_mov=0 same cycle, busy=0, no done.
//    After release, cpu read addr 4 word -> completes normally.
//  2 cpu write word 0xDEADBEEF @8, moc in 1st WAIT -> ram_mov high 2 cycles,
//    cpu_done 4 cycles after req, err=0.
//    Then read @8 with ram_dout=0xDEADBEEF -> rd_data=0xDEADBEEF.
//  3 cpu and ext req same cycle, FIXED_PRIO=0, three rounds held:
//    grants cpu, ext, cpu; owner toggles 0,1,0. FIXED_PRIO=1: cpu every time.
//  4 ext read halfword @3 -> ext_done with err=1, ram_mov never high; word @6 -> err=1;
//    type 3 @0 -> err=1.
//  5 ram_moc held 0 -> exactly TIMEOUT=15 WAIT cycles, then done with err=1;
//    rd_data keeps previous value.
//  6 ext preload loop of 61 byte writes @0..60 with moc after 2 WAIT cycles, while cpu idle
//    -> 61 ext_done pulses, 0 err.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Two-requester (cpu / ext) arbiter and access sequencer for the SPARC RAM.
// Each granted access runs IDLE -> SETUP -> STROBE -> WAIT -> RELEASE; done pulses in RELEASE.
module ram_access_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [1:0]        cpu_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    input  logic              ext_req,
    input  logic              ext_rw,
    input  logic [1:0]        ext_type,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              owner,
    output logic              busy,
    output logic              ram_mov,
    output logic              ram_rw,
    output logic [1:0]        ram_type,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_moc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_RELEASE
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                last_ext_q;
    logic                owner_q;
    logic                err_q;
    logic                cpu_done_q;
    logic                ext_done_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                ram_mov_q;
    logic                ram_rw_q;
    logic [1:0]          ram_type_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;

    logic                grant_ext;
    logic                sel_rw;
    logic [1:0]          sel_type;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_invalid;
    logic [DATA_W-1:0]   rd_ext;

    // On a tie, round-robin hands the grant to whoever was not served last.
    always_comb begin
        grant_ext = ext_req & (~cpu_req | (!FIXED_PRIO && !last_ext_q));
        sel_rw    = grant_ext ? ext_rw    : cpu_rw;
        sel_type  = grant_ext ? ext_type  : cpu_type;
        sel_addr  = grant_ext ? ext_addr  : cpu_addr;
        sel_wdata = grant_ext ? ext_wdata : cpu_wdata;
        sel_invalid = (sel_type == 2'd3)
                    | ((sel_type == 2'd1) & sel_addr[0])
                    | ((sel_type == 2'd2) & (sel_addr[1:0] != 2'b00));
    end

    always_comb begin
        rd_ext = ram_dout;
        case (ram_type_q)
            2'd0:    rd_ext = {{(DATA_W-8){1'b0}},  ram_dout[7:0]};
            2'd1:    rd_ext = {{(DATA_W-16){1'b0}}, ram_dout[15:0]};
            default: rd_ext = ram_dout;
        endcase
    end

    // NOTE: every register, datapath latches included, sits in the async reset so
    // ram_mov and the done pulses drop the instant Clr falls and no stale access survives.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_ext_q <= 1'b1;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            cpu_done_q <= 1'b0;
            ext_done_q <= 1'b0;
            rd_data_q  <= '0;
            ram_mov_q  <= 1'b0;
            ram_rw_q   <= 1'b0;
            ram_type_q <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            // NOTE: non-blocking throughout; the pulses default low and are raised
            // only on the edge that enters RELEASE.
            cpu_done_q <= 1'b0;
            ext_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req | ext_req) begin
                        owner_q    <= grant_ext;
                        last_ext_q <= grant_ext;
                        if (sel_invalid) begin
                            err_q      <= 1'b1;
                            cpu_done_q <= ~grant_ext;
                            ext_done_q <= grant_ext;
                            state_q    <= S_RELEASE;
                        end else begin
                            ram_rw_q   <= sel_rw;
                            ram_type_q <= sel_type;
                            ram_addr_q <= sel_addr;
                            ram_din_q  <= sel_wdata;
                            state_q    <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    ram_mov_q <= 1'b1;
                    state_q   <= S_STROBE;
                end
                S_STROBE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_moc) begin
                        if (ram_rw_q) rd_data_q <= rd_ext;
                        err_q      <= 1'b0;
                        ram_mov_q  <= 1'b0;
                        cpu_done_q <= ~owner_q;
                        ext_done_q <= owner_q;
                        state_q    <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            err_q      <= 1'b1;
                            ram_mov_q  <= 1'b0;
                            cpu_done_q <= ~owner_q;
                            ext_done_q <= owner_q;
                            state_q    <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_done = cpu_done_q;
    assign ext_done = ext_done_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
    assign owner    = owner_q;
    assign busy     = (state_q != S_IDLE);
    assign ram_mov  = ram_mov_q;
    assign ram_rw   = ram_rw_q;
    assign ram_type = ram_type_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_ram_access_arbiter;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [1:0]  cpu_type = '0;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        ext_req = 1'b0, ext_rw = 1'b0;
    logic [1:0]  ext_type = '0;
    logic [8:0]  ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [31:0] ram_dout = '0;
    logic        ram_moc = 1'b0;

    logic        cpu_done, ext_done, err, owner, busy, ram_mov, ram_rw;
    logic [31:0] rd_data, ram_din;
    logic [1:0]  ram_type;
    logic [8:0]  ram_addr;

    logic        f_cpu_done, f_ext_done, f_err, f_owner, f_busy, f_ram_mov, f_ram_rw;
    logic [31:0] f_rd_data, f_ram_din;
    logic [1:0]  f_ram_type;
    logic [8:0]  f_ram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  cap_addr;
    logic [31:0] cap_din;

    always #5 Clk = ~Clk;

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15), .FIXED_PRIO(1'b0)) dut (
        .Clk(Clk), .Clr(Clr),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
        .ext_req(ext_req), .ext_rw(ext_rw), .ext_type(ext_type), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_done(ext_done),
        .rd_data(rd_data), .err(err), .owner(owner), .busy(busy),
        .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_moc(ram_moc)
    );

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15), .FIXED_PRIO(1'b1)) dut_fixed (
        .Clk(Clk), .Clr(Clr),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_done(f_cpu_done),
        .ext_req(ext_req), .ext_rw(ext_rw), .ext_type(ext_type), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_done(f_ext_done),
        .rd_data(f_rd_data), .err(f_err), .owner(f_owner), .busy(f_busy),
        .ram_mov(f_ram_mov), .ram_rw(f_ram_rw), .ram_type(f_ram_type), .ram_addr(f_ram_addr),
        .ram_din(f_ram_din), .ram_dout(ram_dout), .ram_moc(ram_moc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Clr = 1'b0;
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
    endtask

    // Issue one access from a negedge; moc_wait = number of WAIT cycles with moc low first.
    task automatic access(input bit is_ext, input bit rw, input logic [1:0] typ,
                          input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [31:0] dout, input int moc_wait,
                          output int lat, output int movc, output bit errv,
                          output bit own, output logic [31:0] rd);
        bit seen = 1'b0;
        if (is_ext) begin
            ext_req = 1'b1; ext_rw = rw; ext_type = typ; ext_addr = addr; ext_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_rw = rw; cpu_type = typ; cpu_addr = addr; cpu_wdata = wdata;
        end
        ram_dout = dout;
        ram_moc  = 1'b0;
        lat = 0; movc = 0; errv = 1'b0; own = 1'b0; rd = '0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge Clk);
            if (ram_mov) begin
                if (movc == 0) begin
                    cap_addr = ram_addr;
                    cap_din  = ram_din;
                end
                movc++;
            end
            if (is_ext ? ext_done : cpu_done) begin
                seen = 1'b1;
                lat  = c;
                errv = err;
                own  = owner;
                rd   = rd_data;
            end else begin
                ram_moc = (movc >= moc_wait + 2);
            end
        end
        if (!seen) check("done_within_budget", 32'd0, 32'd1);
        cpu_req = 1'b0;
        ext_req = 1'b0;
        ram_moc = 1'b0;
    endtask

    int          lat, movc, ndone, nerr;
    bit          errv, own;
    logic [31:0] rd;
    bit          own0 [3];
    bit          own1 [3];
    int          k0, k1, cpu0, cpu1;

    initial begin
        do_reset();
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_owner", {31'b0, owner}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_ram_mov", {31'b0, ram_mov}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);

        // Reset in the middle of WAIT
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_type = 2'd2; cpu_addr = 9'd0; ram_moc = 1'b0;
        repeat (4) @(negedge Clk);
        check("pre_reset_mov", {31'b0, ram_mov}, 32'd1);
        #2 Clr = 1'b0;
        #1;
        check("async_reset_mov", {31'b0, ram_mov}, 32'd0);
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        cpu_req = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (cpu_done || ext_done) ndone++;
        end
        check("no_done_after_reset", ndone, 32'd0);
        Clr = 1'b1;
        @(negedge Clk);
        access(1'b0, 1'b1, 2'd2, 9'd4, 32'h0, 32'h12345678, 0, lat, movc, errv, own, rd);
        check("post_reset_read_err", {31'b0, errv}, 32'd0);
        check("post_reset_read_data", rd, 32'h12345678);

        // Word write then read back
        do_reset();
        access(1'b0, 1'b0, 2'd2, 9'd8, 32'hDEADBEEF, 32'h0, 0, lat, movc, errv, own, rd);
        check("wr_latency", lat, 32'd4);
        check("wr_mov_cycles", movc, 32'd2);
        check("wr_err", {31'b0, errv}, 32'd0);
        check("wr_ram_addr", {23'b0, cap_addr}, 32'd8);
        check("wr_ram_din", cap_din, 32'hDEADBEEF);
        check("wr_rd_data_untouched", rd, 32'h0);
        access(1'b0, 1'b1, 2'd2, 9'd8, 32'h0, 32'hDEADBEEF, 0, lat, movc, errv, own, rd);
        check("rd_word_data", rd, 32'hDEADBEEF);
        check("rd_owner_cpu", {31'b0, own}, 32'd0);

        // Sub-word reads are zero-extended
        access(1'b0, 1'b1, 2'd0, 9'd5, 32'h0, 32'hAABBCCDD, 0, lat, movc, errv, own, rd);
        check("rd_byte_zext", rd, 32'h000000DD);
        access(1'b0, 1'b1, 2'd1, 9'd2, 32'h0, 32'hAABBCCDD, 0, lat, movc, errv, own, rd);
        check("rd_half_zext", rd, 32'h0000CCDD);

        // Simultaneous requests, held for three rounds
        do_reset();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_type = 2'd2; cpu_addr = 9'd16; cpu_wdata = 32'h1;
        ext_req = 1'b1; ext_rw = 1'b0; ext_type = 2'd2; ext_addr = 9'd20; ext_wdata = 32'h2;
        ram_moc = 1'b1;
        k0 = 0; k1 = 0; cpu0 = 0; cpu1 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if ((cpu_done || ext_done) && k0 < 3) begin
                own0[k0] = owner;
                if (cpu_done) cpu0++;
                k0++;
            end
            if ((f_cpu_done || f_ext_done) && k1 < 3) begin
                own1[k1] = f_owner;
                if (f_cpu_done) cpu1++;
                k1++;
            end
        end
        cpu_req = 1'b0; ext_req = 1'b0; ram_moc = 1'b0;
        check("rr_rounds", k0, 32'd3);
        check("rr_owner0", {31'b0, own0[0]}, 32'd0);
        check("rr_owner1", {31'b0, own0[1]}, 32'd1);
        check("rr_owner2", {31'b0, own0[2]}, 32'd0);
        check("rr_cpu_dones", cpu0, 32'd2);
        check("fixed_rounds", k1, 32'd3);
        check("fixed_owner0", {31'b0, own1[0]}, 32'd0);
        check("fixed_owner1", {31'b0, own1[1]}, 32'd0);
        check("fixed_owner2", {31'b0, own1[2]}, 32'd0);
        check("fixed_cpu_dones", cpu1, 32'd3);

        // Invalid accesses from ext: never strobe the RAM
        do_reset();
        access(1'b1, 1'b1, 2'd1, 9'd3, 32'h0, 32'h0, 0, lat, movc, errv, own, rd);
        check("inv_half_err", {31'b0, errv}, 32'd1);
        check("inv_half_mov", movc, 32'd0);
        check("inv_half_owner", {31'b0, own}, 32'd1);
        check("inv_half_latency", lat, 32'd1);
        access(1'b1, 1'b1, 2'd2, 9'd6, 32'h0, 32'h0, 0, lat, movc, errv, own, rd);
        check("inv_word_err", {31'b0, errv}, 32'd1);
        check("inv_word_mov", movc, 32'd0);
        access(1'b1, 1'b0, 2'd3, 9'd0, 32'h0, 32'h0, 0, lat, movc, errv, own, rd);
        check("inv_type3_err", {31'b0, errv}, 32'd1);
        check("inv_type3_mov", movc, 32'd0);

        // MOC timeout keeps previous read data
        access(1'b0, 1'b1, 2'd2, 9'd12, 32'h0, 32'h0BADF00D, 0, lat, movc, errv, own, rd);
        check("pre_timeout_read", rd, 32'h0BADF00D);
        check("valid_after_invalid_err", {31'b0, errv}, 32'd0);
        access(1'b0, 1'b1, 2'd2, 9'd12, 32'h0, 32'hFFFFFFFF, 1000, lat, movc, errv, own, rd);
        check("timeout_err", {31'b0, errv}, 32'd1);
        check("timeout_wait_cycles", movc - 1, 32'd15);
        check("timeout_rd_kept", rd, 32'h0BADF00D);

        // ext preload: 61 byte writes
        ndone = 0; nerr = 0;
        for (int a = 0; a <= 60; a++) begin
            access(1'b1, 1'b0, 2'd0, 9'(a), 32'(a), 32'h0, 2, lat, movc, errv, own, rd);
            if (lat != 0) ndone++;
            if (errv) nerr++;
        end
        check("preload_dones", ndone, 32'd61);
        check("preload_errs", nerr, 32'd0);
        check("preload_last_addr", {23'b0, ram_addr}, 32'd60);
        check("preload_last_mov_cycles", movc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
